// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the RV32 core.
// Several write ports (highest index wins on a collision), several independent
// read ports with per-port enables, and one clock of read latency in both
// read modes. An asynchronous active-low reset clears all state.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int RD_MODE  = 0,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data
);

    // Architectural state. Register 0 stays a flop even when hardwired to
    // zero: it is reset to 0 and its write strobe is never raised.
    logic [XLEN-1:0] regs [NREGS];

    // Resolved write for this edge, one entry per register. Shared by the
    // register update and by the bypass path so both see the same winner.
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];

    // Write decode: later (higher-index) ports overwrite earlier ones.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] &&
                !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0)) begin
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Register array update; reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            if (RD_MODE == 0) begin : g_addr_mode
                logic [AW-1:0] addr_reg;

                // Capture the read address; the array is read after the edge,
                // so writes landing on this address stay visible.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        addr_reg <= '0;
                    end else if (rd_en[gi]) begin
                        addr_reg <= rd_addr[gi*AW +: AW];
                    end
                end

                assign rd_data[gi*XLEN +: XLEN] = regs[addr_reg];
            end else begin : g_snap_mode
                logic [AW-1:0]   addr_now;
                logic [XLEN-1:0] snap_next;
                logic [XLEN-1:0] snap_reg;

                assign addr_now = rd_addr[gi*AW +: AW];

                // Snapshot source: the winning same-edge write when forwarding
                // is enabled, otherwise the value held before this edge.
                always_comb begin
                    snap_next = regs[addr_now];
                    if (BYPASS != 0 && wr_hit[addr_now]) begin
                        snap_next = wr_val[addr_now];
                    end
                end

                // Snapshot register: only an enabled capture changes it.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        snap_reg <= '0;
                    end else if (rd_en[gi]) begin
                        snap_reg <= snap_next;
                    end
                end

                assign rd_data[gi*XLEN +: XLEN] = snap_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a directed vector table shared by three
// 32-bit configurations, followed by random traffic on a 64-bit, 16-entry,
// 3-read/2-write configuration checked against a behavioural model.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    // Shared stimulus for the three 32-bit instances (NRD=2, NWR=2).
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [63:0] rd_data0;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;

    // Sweep instance stimulus.
    logic [2:0]   s_rd_en;
    logic [11:0]  s_rd_addr;
    logic [191:0] s_rd_data;
    logic [1:0]   s_wr_en;
    logic [7:0]   s_wr_addr;
    logic [127:0] s_wr_data;

    int errors = 0;
    int checks = 0;

    // u0: address-registered reads, hardwired x0
    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .NWR(2),
                 .ZERO_REG(1), .RD_MODE(0), .BYPASS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    // u1: data snapshot with same-edge forwarding, hardwired x0
    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .NWR(2),
                 .ZERO_REG(1), .RD_MODE(1), .BYPASS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    // u2: data snapshot without forwarding, x0 is ordinary storage
    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .NWR(2),
                 .ZERO_REG(0), .RD_MODE(1), .BYPASS(0)) u2 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    // u3: parameter sweep configuration
    regfile_mp #(.XLEN(64), .NREGS(16), .AW(4), .NRD(3), .NWR(2),
                 .ZERO_REG(1), .RD_MODE(0), .BYPASS(1)) u3 (
        .clk(clk), .rst_n(rst_n), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [1:0]  wr_en;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  rd_en;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e00;   // expected u0 port0
        logic [31:0] e01;   // expected u0 port1
        logic [31:0] e10;
        logic [31:0] e11;
        logic [31:0] e20;
        logic [31:0] e21;
    } vec_t;

    localparam int NROWS = 19;
    vec_t tbl [NROWS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_row(input int i, input string tag);
        chk($sformatf("r%0d_%s_u0p0", i, tag), {32'h0, rd_data0[31:0]},  {32'h0, tbl[i].e00});
        chk($sformatf("r%0d_%s_u0p1", i, tag), {32'h0, rd_data0[63:32]}, {32'h0, tbl[i].e01});
        chk($sformatf("r%0d_%s_u1p0", i, tag), {32'h0, rd_data1[31:0]},  {32'h0, tbl[i].e10});
        chk($sformatf("r%0d_%s_u1p1", i, tag), {32'h0, rd_data1[63:32]}, {32'h0, tbl[i].e11});
        chk($sformatf("r%0d_%s_u2p0", i, tag), {32'h0, rd_data2[31:0]},  {32'h0, tbl[i].e20});
        chk($sformatf("r%0d_%s_u2p1", i, tag), {32'h0, rd_data2[63:32]}, {32'h0, tbl[i].e21});
    endtask

    // Sweep scoreboard state
    logic [63:0] mregs [16];
    logic [3:0]  mcap  [3];

    initial begin
        // rst, wr_en, wa0, wd0, wa1, wd1, rd_en, ra0, ra1, u0p0, u0p1, u1p0, u1p1, u2p0, u2p1
        tbl[0]  = '{1'b1, 2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,    2'b00, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd5, 5'd5,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 2'b01, 5'd5,  32'h12345678, 5'd0,  32'h0,    2'b11, 5'd5, 5'd5,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd5, 5'd5,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,    2'b00, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[6]  = '{1'b1, 2'b11, 5'd7,  32'h11,       5'd7,  32'h22,   2'b00, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[7]  = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd7, 5'd7,
                    32'h22, 32'h22, 32'h22, 32'h22, 32'h22, 32'h22};
        tbl[8]  = '{1'b1, 2'b01, 5'd3,  32'h1,        5'd0,  32'h0,    2'b00, 5'd7, 5'd7,
                    32'h22, 32'h22, 32'h22, 32'h22, 32'h22, 32'h22};
        tbl[9]  = '{1'b1, 2'b01, 5'd3,  32'hA5A5,     5'd0,  32'h0,    2'b01, 5'd3, 5'd7,
                    32'hA5A5, 32'h22, 32'hA5A5, 32'h22, 32'h1, 32'h22};
        tbl[10] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b01, 5'd3, 5'd7,
                    32'hA5A5, 32'h22, 32'hA5A5, 32'h22, 32'hA5A5, 32'h22};
        tbl[11] = '{1'b1, 2'b01, 5'd9,  32'h100,      5'd0,  32'h0,    2'b00, 5'd3, 5'd7,
                    32'hA5A5, 32'h22, 32'hA5A5, 32'h22, 32'hA5A5, 32'h22};
        tbl[12] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd9, 5'd9,
                    32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
        tbl[13] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b00, 5'd4, 5'd4,
                    32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
        tbl[14] = '{1'b1, 2'b01, 5'd9,  32'h200,      5'd0,  32'h0,    2'b00, 5'd4, 5'd4,
                    32'h200, 32'h200, 32'h100, 32'h100, 32'h100, 32'h100};
        tbl[15] = '{1'b1, 2'b11, 5'd12, 32'h77,       5'd0,  32'hBAD,  2'b11, 5'd0, 5'd12,
                    32'h0, 32'h77, 32'h0, 32'h77, 32'hFFFFFFFF, 32'h0};
        tbl[16] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b01, 5'd0, 5'd12,
                    32'h0, 32'h77, 32'h0, 32'h77, 32'hBAD, 32'h0};
        tbl[17] = '{1'b1, 2'b11, 5'd20, 32'hAAAA,     5'd20, 32'hBBBB, 2'b11, 5'd20, 5'd20,
                    32'hBBBB, 32'hBBBB, 32'hBBBB, 32'hBBBB, 32'h0, 32'h0};
        tbl[18] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b10, 5'd1, 5'd20,
                    32'hBBBB, 32'hBBBB, 32'hBBBB, 32'hBBBB, 32'h0, 32'hBBBB};

        // Power-on reset
        rst_n = 1'b0;
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        s_rd_en = '0; s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_u0", rd_data0, 64'h0);
        chk("reset_u1", rd_data1, 64'h0);
        chk("reset_u2", rd_data2, 64'h0);
        chk("reset_u3_p0", s_rd_data[63:0],    64'h0);
        chk("reset_u3_p1", s_rd_data[127:64],  64'h0);
        chk("reset_u3_p2", s_rd_data[191:128], 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk);
            rst_n   = tbl[i].rst_n;
            wr_en   = tbl[i].wr_en;
            wr_addr = {tbl[i].wa1, tbl[i].wa0};
            wr_data = {tbl[i].wd1, tbl[i].wd0};
            rd_en   = tbl[i].rd_en;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            if (!tbl[i].rst_n) begin
                #1;
                check_row(i, "async");
            end
            @(posedge clk);
            #1;
            check_row(i, "edge");
            $display("row %0d: rst_n=%0b wr_en=%b rd_en=%b u0=%h u1=%h u2=%h",
                     i, tbl[i].rst_n, tbl[i].wr_en, tbl[i].rd_en, rd_data0, rd_data1, rd_data2);
        end

        @(negedge clk);
        wr_en = '0;
        rd_en = '0;

        // Random sweep on u3 against a behavioural model
        for (int r = 0; r < 16; r++) mregs[r] = '0;
        for (int p = 0; p < 3; p++) mcap[p] = '0;

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            s_wr_en   = 2'($urandom_range(0, 3));
            s_wr_addr[3:0] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s_wr_addr[7:4] = s_wr_addr[3:0];
            else                           s_wr_addr[7:4] = 4'($urandom_range(0, 15));
            s_wr_data = {$urandom, $urandom, $urandom, $urandom};
            s_rd_en   = 3'($urandom_range(0, 7));
            s_rd_addr = 12'($urandom_range(0, 4095));
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                if (s_wr_en[j] && s_wr_addr[j*4 +: 4] != 4'd0)
                    mregs[s_wr_addr[j*4 +: 4]] = s_wr_data[j*64 +: 64];
            end
            for (int p = 0; p < 3; p++) begin
                if (s_rd_en[p]) mcap[p] = s_rd_addr[p*4 +: 4];
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("sweep_c%0d_p%0d", c, p), s_rd_data[p*64 +: 64], mregs[mcap[p]]);
            end
            if ((c % 1000) == 999)
                $display("sweep cycles=%0d errors=%0d", c + 1, errors);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
